vdg_video_fetch: RTL and testbench
==================================

Name: vdg_video_fetch

Overview:
- SAM-side responder to the VDG display-address interface.
- Watches the VDG's DA0, HSn and FSn outputs and maintains the real 16-bit video address, including per-mode row repetition (÷1/÷2/÷3/÷12).
- Issues single-byte reads to display RAM and returns the byte on Q.
- Sits between the VDG core and the RAM arbiter, all on the NTSC pixel clock domain.

Parameters:
- ADDR_W, 16, memory address width.
- BASE_W, 7, width of display base field; base unit is 512 bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- da0  in  1  VDG DA bit 0; each transition (either edge) requests one byte
- hsn  in  1  VDG horizontal sync, active low
- fsn  in  1  VDG field sync, active low
- vmode  in  3  row-divide mode (SAM V2..V0)
- base  in  BASE_W  display start, in 512-byte units
- mem_req  out  1  read request to RAM arbiter
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  one-cycle pulse; mem_data valid in the same cycle
- mem_data  in  8  read data
- q  out  8  byte to VDG Q bus, held until next fetch completes
- q_valid  out  1  one-cycle pulse when q updates
- underrun  out  1  sticky: a request was dropped

Behaviour:
- Reset: mem_req=0, mem_addr=0, q=0x00, q_valid=0, underrun=0, addr=0, row_start=0, rep_cnt=0, queue empty, edge registers cleared.
  - Reset mid-transaction drops mem_req in the next cycle. A later mem_ack is ignored.
- Inputs da0, hsn and fsn are registered once. Edges are detected on the registered copy.
  - Request-to-mem_req latency is 2 cycles from the da0 transition when the queue is idle.
- Divisor by vmode (latched into vmode_q at each hsn falling edge and at fsn falling edge):
  - 0 → 12 (alpha/semigraphics)
  - 1, 2 → 3
  - 3, 4 → 2
  - 5, 6, 7 → 1
- fsn falling edge has highest priority:
  - addr = row_start = {base, 9'b0}; rep_cnt=0; underrun cleared; queue cleared.
  - An in-flight request still completes, and its ack still updates q.
- da0 edge:
  - Enqueue the current addr; addr = addr+1, wrapping 0xFFFF→0x0000.
- hsn falling edge:
  - If rep_cnt < div-1: rep_cnt++ and addr = row_start (rewind).
  - Otherwise: rep_cnt=0 and row_start = addr (advance).
- da0 edge and hsn falling edge in the same cycle:
  - The enqueue uses the pre-increment addr.
  - Rewind overrides the increment. Advance takes the incremented addr.
- Request queue is 2-entry: one in-flight plus one pending.
  - States: IDLE, REQ (mem_req=1, waiting for mem_ack), REQ_PEND (REQ with one pending address).
  - IDLE + enqueue → REQ.
  - REQ + ack → IDLE.
  - REQ + enqueue → REQ_PEND.
  - REQ_PEND + ack → REQ. mem_addr takes the pending address next cycle; mem_req is held.
  - Ack and enqueue in the same cycle from REQ → REQ with the new address. This is not an underrun.
  - Enqueue while in REQ_PEND with no ack: the new address is dropped and underrun=1.
- On any accepted ack: q = mem_data and q_valid=1 the next cycle.
- mem_addr must not change while mem_req=1 until ack.

Decomposition:
- Shared package vdg_pkg holds:
  - the vmode encodings
  - the divisor function div_for_mode(vmode)
  - the BASE_SHIFT=9 constant
- One natural sub-module, vdg_row_divider, owns rep_cnt, row_start, the rewind/advance decision and the vmode latch.
- The top level holds the edge detectors, the address counter and the request queue FSM.

Test Plan:
- vmode=6, base=0x02, fsn pulse, 32 da0 toggles, hsn pulse, 32 toggles → addresses 0x0400..0x041F, then 0x0420..0x043F.
- vmode=0, base=0x02, 13 rows of 32 toggles each → rows 1–12 all fetch 0x0400..0x041F; row 13 starts at 0x0420.
- vmode=1 → three identical rows, then advance. Change vmode to 3 mid-field → the new ÷2 takes effect from the next hsn falling edge only.
- Ack stalled, 3 da0 toggles → first two addresses fetched in order, third dropped, underrun=1. Next fsn falling edge clears underrun.
- Ack and da0 toggle in the same cycle with one in flight → no underrun, mem_req stays high, q_valid pulses with the acked byte.
- addr=0xFFFF then one da0 toggle → fetch 0xFFFF, next fetch 0x0000. Assert reset during REQ → mem_req=0 next cycle, q stays 0x00 despite a late ack.

Source files
------------

// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG display-address responder: mode encodings,
// request-queue states and the row-repeat divisor lookup.
package vdg_pkg;

    localparam int BASE_SHIFT = 9;
    localparam int REP_W      = 4;

    typedef enum logic [2:0] {
        VM_ALPHA  = 3'd0,
        VM_DIV3_A = 3'd1,
        VM_DIV3_B = 3'd2,
        VM_DIV2_A = 3'd3,
        VM_DIV2_B = 3'd4,
        VM_DIV1_A = 3'd5,
        VM_DIV1_B = 3'd6,
        VM_DIV1_C = 3'd7
    } vmode_e;

    typedef enum logic [1:0] {
        Q_IDLE     = 2'd0,
        Q_REQ      = 2'd1,
        Q_REQ_PEND = 2'd2
    } qstate_e;

    function automatic logic [REP_W-1:0] div_for_mode(input logic [2:0] vmode);
        logic [REP_W-1:0] div;
        div = 4'd1;
        case (vmode_e'(vmode))
            VM_ALPHA:             div = 4'd12;
            VM_DIV3_A, VM_DIV3_B: div = 4'd3;
            VM_DIV2_A, VM_DIV2_B: div = 4'd2;
            default:              div = 4'd1;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/vdg_video_fetch_if.sv
// Display-RAM read port between the fetch unit (master) and the RAM arbiter (slave).
interface vdg_video_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/vdg_row_divider.sv
// Row repetition: counts hsn falling edges and decides whether the next scan line
// rewinds to the current row start or advances to the live address.
module vdg_row_divider
    import vdg_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fsn_fall_i,
    input  logic              hsn_fall_i,
    input  logic [2:0]        vmode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] addr_inc_i,
    output logic [ADDR_W-1:0] row_start_o,
    output logic              rewind_o
);
    logic [2:0]        vmode_q;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [ADDR_W-1:0] row_start_q;
    logic [REP_W-1:0]  div_m1;

    assign div_m1      = div_for_mode(vmode_q) - 4'd1;
    assign rewind_o    = hsn_fall_i && !fsn_fall_i && (rep_cnt_q < div_m1);
    assign row_start_o = row_start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vmode_q     <= '0;
            rep_cnt_q   <= '0;
            row_start_q <= '0;
        end else if (fsn_fall_i) begin
            vmode_q     <= vmode_i;
            rep_cnt_q   <= '0;
            row_start_q <= base_addr_i;
        end else if (hsn_fall_i) begin
            // The divisor for this edge is the one latched at the previous sync edge.
            vmode_q <= vmode_i;
            if (rewind_o) begin
                rep_cnt_q <= rep_cnt_q + 4'd1;
            end else begin
                rep_cnt_q   <= '0;
                row_start_q <= addr_inc_i;
            end
        end
    end

endmodule

// File: rtl/vdg_video_fetch.sv
// SAM-side video fetch: tracks the VDG display address from DA0/HSn/FSn and
// issues single-byte reads through a two-entry request queue.
module vdg_video_fetch
    import vdg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BASE_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               da0,
    input  logic               hsn,
    input  logic               fsn,
    input  logic [2:0]         vmode,
    input  logic [BASE_W-1:0]  base,
    vdg_video_fetch_if.master  mem,
    output logic [7:0]         q,
    output logic               q_valid,
    output logic               underrun
);
    logic da0_q, da0_prev_q, hsn_q, hsn_prev_q, fsn_q, fsn_prev_q;
    logic da0_edge, hsn_fall, fsn_fall, enq, ack, rewind;

    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, row_start, base_addr;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, pend_addr_q, pend_addr_d;
    logic [7:0]        q_q, q_d;
    logic              q_valid_q, q_valid_d, underrun_q, underrun_d;
    qstate_e           state_q, state_d;

    assign da0_edge  = da0_q ^ da0_prev_q;
    assign hsn_fall  = hsn_prev_q & ~hsn_q;
    assign fsn_fall  = fsn_prev_q & ~fsn_q;
    assign enq       = da0_edge & ~fsn_fall;
    assign ack       = mem.mem_ack & (state_q != Q_IDLE);
    assign base_addr = ADDR_W'({base, {BASE_SHIFT{1'b0}}});
    assign addr_inc  = enq ? addr_q + 1'b1 : addr_q;

    vdg_row_divider #(.ADDR_W(ADDR_W)) u_row_divider (
        .clk         (clk),
        .reset       (reset),
        .fsn_fall_i  (fsn_fall),
        .hsn_fall_i  (hsn_fall),
        .vmode_i     (vmode),
        .base_addr_i (base_addr),
        .addr_inc_i  (addr_inc),
        .row_start_o (row_start),
        .rewind_o    (rewind)
    );

    always_comb begin
        addr_d = addr_inc;
        if (fsn_fall)    addr_d = base_addr;
        else if (rewind) addr_d = row_start;
    end

    // Queue FSM; enq always carries the pre-increment address addr_q.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        pend_addr_d = pend_addr_q;
        underrun_d  = fsn_fall ? 1'b0 : underrun_q;
        q_d         = ack ? mem.mem_data : q_q;
        q_valid_d   = ack;
        case (state_q)
            Q_IDLE: begin
                if (enq) begin
                    state_d    = Q_REQ;
                    mem_addr_d = addr_q;
                end
            end
            Q_REQ: begin
                if (ack && enq) begin
                    mem_addr_d = addr_q;
                end else if (ack) begin
                    state_d = Q_IDLE;
                end else if (enq) begin
                    state_d     = Q_REQ_PEND;
                    pend_addr_d = addr_q;
                end
            end
            Q_REQ_PEND: begin
                if (fsn_fall) begin
                    state_d = ack ? Q_IDLE : Q_REQ;
                end else if (ack) begin
                    mem_addr_d = pend_addr_q;
                    if (enq) pend_addr_d = addr_q;
                    else     state_d     = Q_REQ;
                end else if (enq) begin
                    underrun_d = 1'b1;
                end
            end
            default: state_d = Q_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            da0_q       <= 1'b0;
            da0_prev_q  <= 1'b0;
            hsn_q       <= 1'b0;
            hsn_prev_q  <= 1'b0;
            fsn_q       <= 1'b0;
            fsn_prev_q  <= 1'b0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            pend_addr_q <= '0;
            q_q         <= 8'h00;
            q_valid_q   <= 1'b0;
            underrun_q  <= 1'b0;
            state_q     <= Q_IDLE;
        end else begin
            da0_q       <= da0;
            da0_prev_q  <= da0_q;
            hsn_q       <= hsn;
            hsn_prev_q  <= hsn_q;
            fsn_q       <= fsn;
            fsn_prev_q  <= fsn_q;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            pend_addr_q <= pend_addr_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            underrun_q  <= underrun_d;
            state_q     <= state_d;
        end
    end

    assign mem.mem_req  = (state_q != Q_IDLE);
    assign mem.mem_addr = mem_addr_q;
    assign q            = q_q;
    assign q_valid      = q_valid_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_vdg_video_fetch.sv
// Directed bench for vdg_video_fetch: RAM responder with fetch log, q scoreboard,
// row-repeat, underrun, same-cycle ack/enqueue, wrap and reset-abort cases.
module tb_vdg_video_fetch;

    logic       clk = 1'b0;
    logic       reset, da0, hsn, fsn;
    logic [2:0] vmode;
    logic [6:0] base;
    logic [7:0] q;
    logic       q_valid, underrun;

    logic        ack_en, auto_ack, man_ack;
    logic [7:0]  auto_data, man_data, exp_q;
    logic [15:0] fetched[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    vdg_video_fetch_if #(.ADDR_W(16)) mem_bus ();

    vdg_video_fetch #(.ADDR_W(16), .BASE_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .da0      (da0),
        .hsn      (hsn),
        .fsn      (fsn),
        .vmode    (vmode),
        .base     (base),
        .mem      (mem_bus.master),
        .q        (q),
        .q_valid  (q_valid),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    assign mem_bus.mem_ack  = auto_ack | man_ack;
    assign mem_bus.mem_data = auto_ack ? auto_data : man_data;

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Auto-responder: one-cycle ack, logs each address it serves.
    always @(negedge clk) begin
        if (ack_en && mem_bus.mem_req && !auto_ack && !reset) begin
            auto_ack  <= 1'b1;
            auto_data <= ram_byte(mem_bus.mem_addr);
            fetched.push_back(mem_bus.mem_addr);
            $display("fetch addr=0x%04h", mem_bus.mem_addr);
        end else begin
            auto_ack <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset && mem_bus.mem_req && mem_bus.mem_ack) exp_q <= mem_bus.mem_data;
    end

    always @(negedge clk) begin
        if (q_valid) check_eq("q_data", {24'h0, q}, {24'h0, exp_q});
    end

    task automatic toggle();
        da0 = ~da0;
        repeat (4) @(negedge clk);
    endtask

    task automatic hsn_pulse();
        hsn = 1'b0;
        repeat (2) @(negedge clk);
        hsn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic fsn_pulse();
        fsn = 1'b0;
        repeat (2) @(negedge clk);
        fsn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_row(input string tag, input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_avail"}, {31'h0, fetched.size() > 0}, 32'h1);
            if (fetched.size() > 0)
                check_eq(tag, {16'h0, fetched.pop_front()}, {16'h0, start + 16'(i)});
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_bus.mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'h0, mem_bus.mem_req}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; da0 = 1'b0; hsn = 1'b1; fsn = 1'b1;
        vmode = 3'd0; base = 7'd0;
        ack_en = 1'b0; man_ack = 1'b0; man_data = 8'h00; exp_q = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req",  {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("rst_mem_addr", {16'h0, mem_bus.mem_addr}, 32'h0);
        check_eq("rst_q",        {24'h0, q}, 32'h0);
        check_eq("rst_q_valid",  {31'h0, q_valid}, 32'h0);
        check_eq("rst_underrun", {31'h0, underrun}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Divide-by-1: two consecutive rows
        ack_en = 1'b1; vmode = 3'd6; base = 7'h02;
        fsn_pulse(); fetched.delete();
        repeat (32) toggle();
        hsn_pulse();
        repeat (32) toggle();
        check_row("m6_row0", 16'h0400, 32);
        check_row("m6_row1", 16'h0420, 32);

        // Divide-by-12: twelve identical rows then advance
        vmode = 3'd0;
        fsn_pulse(); fetched.delete();
        for (int r = 0; r < 13; r++) begin
            repeat (32) toggle();
            if (r < 12) hsn_pulse();
        end
        for (int r = 0; r < 12; r++) check_row("m0_rep", 16'h0400, 32);
        check_row("m0_row13", 16'h0420, 32);

        // Divide-by-3, then switch to divide-by-2 mid-row
        vmode = 3'd1;
        fsn_pulse(); fetched.delete();
        for (int r = 0; r < 3; r++) begin
            repeat (4) toggle();
            hsn_pulse();
        end
        repeat (2) toggle();
        vmode = 3'd3;
        repeat (2) toggle();
        hsn_pulse();
        repeat (4) toggle();
        hsn_pulse();
        repeat (4) toggle();
        for (int r = 0; r < 3; r++) check_row("m1_rep", 16'h0400, 4);
        check_row("m3_row4", 16'h0404, 4);
        check_row("m3_row5", 16'h0404, 4);
        check_row("m3_row6", 16'h0408, 4);

        // Stalled ack: third request dropped
        ack_en = 1'b0; vmode = 3'd6;
        fsn_pulse(); fetched.delete();
        repeat (2) toggle();
        check_eq("stall_underrun0", {31'h0, underrun}, 32'h0);
        check_eq("stall_req",       {31'h0, mem_bus.mem_req}, 32'h1);
        toggle();
        check_eq("stall_underrun1", {31'h0, underrun}, 32'h1);
        check_eq("stall_addr",      {16'h0, mem_bus.mem_addr}, 32'h0400);
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        check_row("stall_fetch", 16'h0400, 2);
        check_eq("stall_dropped", fetched.size(), 32'h0);
        fsn_pulse();
        check_eq("fsn_clr_underrun", {31'h0, underrun}, 32'h0);

        // Latency, then ack and enqueue in the same cycle
        ack_en = 1'b0;
        repeat (4) @(negedge clk);
        da0 = ~da0;
        @(negedge clk);
        check_eq("lat_cycle1", {31'h0, mem_bus.mem_req}, 32'h0);
        @(negedge clk);
        check_eq("lat_cycle2", {31'h0, mem_bus.mem_req}, 32'h1);
        check_eq("lat_addr",   {16'h0, mem_bus.mem_addr}, 32'h0400);
        da0 = ~da0;
        @(negedge clk);
        man_ack = 1'b1; man_data = 8'hA5;
        @(negedge clk);
        man_ack = 1'b0;
        check_eq("same_req",      {31'h0, mem_bus.mem_req}, 32'h1);
        check_eq("same_addr",     {16'h0, mem_bus.mem_addr}, 32'h0401);
        check_eq("same_underrun", {31'h0, underrun}, 32'h0);
        check_eq("same_q_valid",  {31'h0, q_valid}, 32'h1);
        check_eq("same_q",        {24'h0, q}, 32'hA5);
        man_ack = 1'b1; man_data = 8'h11;
        @(negedge clk);
        man_ack = 1'b0;
        check_eq("same_drain_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("same_drain_q",   {24'h0, q}, 32'h11);

        // Address wrap 0xFFFF -> 0x0000
        ack_en = 1'b1; vmode = 3'd7; base = 7'h7F;
        fsn_pulse(); fetched.delete();
        repeat (511) toggle();
        check_eq("wrap_pre", {16'h0, fetched[$]}, 32'hFFFE);
        fetched.delete();
        repeat (2) toggle();
        check_row("wrap", 16'hFFFF, 2);

        // Reset while a request is outstanding; late ack ignored
        ack_en = 1'b0;
        toggle();
        wait_req("rst_req_up");
        check_eq("rst_req_addr", {16'h0, mem_bus.mem_addr}, 32'h0001);
        reset = 1'b1; da0 = 1'b0;
        @(negedge clk);
        check_eq("rst_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("rst_q_clear",  {24'h0, q}, 32'h0);
        reset = 1'b0;
        man_ack = 1'b1; man_data = 8'h5A;
        @(negedge clk);
        man_ack = 1'b0;
        check_eq("late_ack_q_valid", {31'h0, q_valid}, 32'h0);
        check_eq("late_ack_q",       {24'h0, q}, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("late_ack_req", {31'h0, mem_bus.mem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
